uart_rx: RTL and testbench

UART receiver stage that consumes the one-cycle 16×-oversampling tick from the baud-rate generator and deserialises the asynchronous serial line into parallel bytes. It sits directly downstream of the baud-rate generator, and its outputs feed the receive FIFO and the interface logic. The block synchronises the `RX` line, qualifies the start bit at mid-bit, samples each data bit at its centre and checks the stop bit. It reports each completed frame with a one-cycle strobe.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with start-bit
// qualification, centre sampling and stop-bit framing check.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RX,
  input  logic            S_TICK,
  output logic [DBIT-1:0] DOUT,
  output logic            RX_DONE_TICK,
  output logic            FRAME_ERR,
  output logic            BUSY
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     s_q;
  logic [NW-1:0]     n_q;
  logic [DBIT-1:0]   b_q;
  logic [DBIT-1:0]   dout_q;
  logic              ferr_q;
  logic              done_q;
  logic [1:0]        sync_q;
  logic              rx_s;

  assign rx_s = sync_q[1];

  // Two-stage synchroniser for the asynchronous serial line.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX};
    end
  end

  // Receive FSM with registered data, error and done outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (S_TICK) begin
            if (s_q == S_MID) begin
              if (rx_s) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        DATA: begin
          if (S_TICK) begin
            if (s_q == S_END) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        STOP: begin
          if (S_TICK) begin
            if (s_q == S_STOP) begin
              state_q <= IDLE;
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DOUT         = dout_q;
  assign FRAME_ERR    = ferr_q;
  assign RX_DONE_TICK = done_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: a queue of
// sent frames is the reference each completed frame is checked against.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RX1;
  logic       RX2;
  logic       S_TICK;
  logic [7:0] dout1;
  logic [6:0] dout2;
  logic       done1, done2;
  logic       ferr1, ferr2;
  logic       busy1, busy2;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_errors = 0;
  int pulses1  = 0;
  int pulses2  = 0;
  int sent1    = 0;
  int tcnt     = 0;
  time s1_t, s2_t, p1_t, p2_t;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  logic pbusy1 = 1'b0;
  logic pbusy2 = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx dut1 (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX           (RX1),
    .S_TICK       (S_TICK),
    .DOUT         (dout1),
    .RX_DONE_TICK (done1),
    .FRAME_ERR    (ferr1),
    .BUSY         (busy1)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX           (RX2),
    .S_TICK       (S_TICK),
    .DOUT         (dout2),
    .RX_DONE_TICK (done2),
    .FRAME_ERR    (ferr2),
    .BUSY         (busy2)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 16x tick: one CLK high every 4 CLK
  initial begin
    S_TICK = 1'b0;
    forever begin
      @(negedge CLK);
      tcnt++;
      S_TICK = (tcnt % 4 == 0);
    end
  end

  // Completed-frame monitor against the sent-frame queues
  always @(negedge CLK) begin
    exp_t e;
    if (done1) begin
      pulses1++;
      p1_t = $time;
      check("done1_width", 32'(prev1), 32'd0);
      check("busy1_pre", 32'(pbusy1), 32'd1);
      check("q1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dout1", 32'(dout1), 32'(e.d));
        check("ferr1", 32'(ferr1), 32'(e.fe));
      end
    end
    if (done2) begin
      pulses2++;
      p2_t = $time;
      check("done2_width", 32'(prev2), 32'd0);
      check("busy2_pre", 32'(pbusy2), 32'd1);
      check("q2_pending", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("dout2", 32'(dout2), 32'(e.d[6:0]));
        check("ferr2", 32'(ferr2), 32'(e.fe));
      end
    end
    prev1  = done1;
    prev2  = done2;
    pbusy1 = busy1;
    pbusy2 = busy2;
  end

  task automatic set_rx(int line, logic v);
    if (line == 1) RX1 = v;
    else RX2 = v;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge CLK);
  endtask

  // Serialise one frame: 64 CLK per bit, LSB first.
  // A zero stop bit is held 3/4 bit so the line is high again
  // well before the receiver's next start check.
  task automatic send(int line, logic [7:0] d, int nbits,
                      int nstop, logic stop, int abort_at);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
    if (abort_at < 0) begin
      if (line == 1) begin
        q1.push_back(e);
        sent1++;
      end else begin
        q2.push_back(e);
      end
    end
    @(negedge CLK);
    set_rx(line, 1'b0);
    if (line == 1) s1_t = $time;
    else s2_t = $time;
    idle(64);
    for (int k = 0; k < nbits; k++) begin
      set_rx(line, d[k]);
      if (k == abort_at) begin
        idle(32);
        return;
      end
      idle(64);
    end
    if (stop) begin
      set_rx(line, 1'b1);
      idle(64 * nstop);
    end else begin
      set_rx(line, 1'b0);
      idle(48);
      set_rx(line, 1'b1);
      idle(16);
    end
  endtask

  initial begin
    time lat;
    logic [7:0] d;
    logic       st;
    RX1   = 1'b1;
    RX2   = 1'b1;
    RESET = 1'b1;
    idle(3);
    RESET = 1'b0;
    idle(1);
    check("rst_dout1", 32'(dout1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_ferr1", 32'(ferr1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_dout2", 32'(dout2), 32'd0);
    idle(20);

    fork
      send(1, 8'hA5, 8, 1, 1'b1, -1);
      begin
        idle(20);
        check("a5_busy_mid", 32'(busy1), 32'd1);
      end
    join
    lat = (p1_t - s1_t) / 10;
    check("a5_latency", 32'(lat >= 604 && lat <= 616), 32'd1);
    check("a5_dout", 32'(dout1), 32'hA5);
    check("a5_busy_after", 32'(busy1), 32'd0);
    check("a5_pulses", 32'(pulses1), 32'd1);

    RX1 = 1'b0;
    idle(12);
    RX1 = 1'b1;
    idle(100);
    check("glitch_pulses", 32'(pulses1), 32'd1);
    check("glitch_dout", 32'(dout1), 32'hA5);
    check("glitch_busy", 32'(busy1), 32'd0);

    send(1, 8'h3C, 8, 1, 1'b0, -1);
    idle(100);
    check("ferr_dout", 32'(dout1), 32'h3C);
    check("ferr_flag", 32'(ferr1), 32'd1);

    send(1, 8'h00, 8, 1, 1'b1, -1);
    send(1, 8'hFF, 8, 1, 1'b1, -1);
    send(1, 8'h55, 8, 1, 1'b1, -1);
    idle(20);
    check("b2b_pulses", 32'(pulses1), 32'd5);
    check("b2b_dout", 32'(dout1), 32'h55);

    send(1, 8'h81, 8, 1, 1'b1, 4);
    RESET = 1'b1;
    RX1   = 1'b1;
    idle(1);
    check("mrst_dout", 32'(dout1), 32'd0);
    check("mrst_ferr", 32'(ferr1), 32'd0);
    check("mrst_busy", 32'(busy1), 32'd0);
    check("mrst_done", 32'(done1), 32'd0);
    idle(3);
    RESET = 1'b0;
    idle(50);
    check("mrst_pulses", 32'(pulses1), 32'd5);
    send(1, 8'h7E, 8, 1, 1'b1, -1);
    idle(20);
    check("after_rst_dout", 32'(dout1), 32'h7E);

    fork
      send(1, 8'h41, 8, 1, 1'b1, -1);
      send(2, 8'h41, 7, 2, 1'b1, -1);
    join
    idle(20);
    lat = (p2_t - s2_t) / 10;
    check("sb32_latency", 32'(lat >= 604 && lat <= 616), 32'd1);
    check("sb32_vs_8n1", 32'(p2_t == p1_t), 32'd1);
    check("sb32_dout", 32'(dout2), 32'h41);
    check("sb32_pulses", 32'(pulses2), 32'd1);

    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      st = ($urandom % 4) != 0;
      send(1, d, 8, 1, st, -1);
      if (st) idle($urandom % 80);
      else idle(64 + $urandom % 64);
    end
    idle(200);

    check("total_pulses", 32'(pulses1), 32'(sent1));
    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q2_empty", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
